cpu_regfile_param: RTL and testbench

//  Parametrised 6502-style architectural register file (A, X, Y, SP, PC, PS).

---
 rtl/cpu_regfile_param.sv | 136 +++++++++++++
 tb/tb_cpu_regfile_param.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/cpu_regfile_param.sv
// 6502-style architectural register file (A, X, Y, SP, PC, PS) with SP/PC arithmetic,
// masked flag update and a boot FSM that optionally fetches PC from the reset vector.
//
// state  | meaning
// BOOT   | first cycle after reset release
// VEC_LO | requesting reset-vector low byte
// VEC_HI | requesting reset-vector high byte
// RUN    | normal operation, register updates accepted
module cpu_regfile_param #(
    parameter int              DW          = 8,
    parameter int              AW          = 16,
    parameter bit              USE_VECTOR  = 1'b1,
    parameter logic [AW-1:0]   VEC_ADDR    = 16'hFFFC,
    parameter logic [AW-1:0]   PC_RESET    = 16'h1000,
    parameter logic [DW-1:0]   SP_RESET    = 8'hFD,
    parameter logic [DW-1:0]   PS_RESET    = 8'h34,
    parameter logic [DW-1:0]   PS_ONE_MASK = 8'h20
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          we_a,
    input  logic          we_x,
    input  logic          we_y,
    input  logic          we_sp,
    input  logic [DW-1:0] data_in,
    input  logic [1:0]    sp_op,
    input  logic [1:0]    pc_op,
    input  logic [1:0]    pc_inc,
    input  logic [AW-1:0] pc_in,
    input  logic          ps_we,
    input  logic [DW-1:0] ps_mask,
    input  logic [DW-1:0] ps_flags,
    input  logic [DW-1:0] vec_data,
    input  logic          vec_ack,
    output logic          vec_req,
    output logic [AW-1:0] vec_addr,
    output logic          ready,
    output logic [DW-1:0] A,
    output logic [DW-1:0] X,
    output logic [DW-1:0] Y,
    output logic [DW-1:0] SP,
    output logic [AW-1:0] PC,
    output logic [DW-1:0] PS
);

    typedef enum logic [1:0] {BOOT, VEC_LO, VEC_HI, RUN} state_t;

    state_t state, state_next;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= BOOT;
        else       state <= state_next;
    end

    // Outputs decode from the state register only, so no input reaches them combinationally.
    always_comb begin
        state_next = state;
        vec_req    = 1'b0;
        vec_addr   = '0;
        ready      = 1'b0;
        case (state)
            BOOT: begin
                state_next = USE_VECTOR ? VEC_LO : RUN;
            end
            VEC_LO: begin
                vec_req  = 1'b1;
                vec_addr = VEC_ADDR;
                if (vec_ack) state_next = VEC_HI;
            end
            VEC_HI: begin
                vec_req  = 1'b1;
                vec_addr = VEC_ADDR + AW'(1);
                if (vec_ack) state_next = RUN;
            end
            RUN: begin
                ready = 1'b1;
            end
            default: state_next = BOOT;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            A <= '0;
            X <= '0;
            Y <= '0;
        end else if (ready) begin
            if (we_a) A <= data_in;
            if (we_x) X <= data_in;
            if (we_y) Y <= data_in;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            SP <= SP_RESET;
        end else if (ready) begin
            if (we_sp) begin
                SP <= data_in;
            end else begin
                case (sp_op)
                    2'b01:   SP <= SP + DW'(1);
                    2'b10:   SP <= SP - DW'(1);
                    default: SP <= SP;
                endcase
            end
        end
    end

    // Vector bytes land directly in PC; a reset mid-fetch restores PC_RESET.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            PC <= PC_RESET;
        end else if (state == VEC_LO && vec_ack) begin
            PC[DW-1:0] <= vec_data;
        end else if (state == VEC_HI && vec_ack) begin
            PC[AW-1:DW] <= vec_data;
        end else if (ready) begin
            case (pc_op)
                2'b01:   PC <= PC + AW'(pc_inc);
                2'b10:   PC <= pc_in;
                default: PC <= PC;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            PS <= PS_RESET | PS_ONE_MASK;
        end else if (ready) begin
            if (ps_we) PS <= data_in | PS_ONE_MASK;
            else       PS <= (PS & ~ps_mask) | (ps_flags & ps_mask) | PS_ONE_MASK;
        end
    end

endmodule

// File: tb/tb_cpu_regfile_param.sv
// Directed bench for cpu_regfile_param: vector fetch, direct boot, register ops, reset mid-fetch.
module tb_cpu_regfile_param;

    logic        clk = 1'b0;
    logic        reset;
    logic        we_a, we_x, we_y, we_sp, ps_we, vec_ack;
    logic [7:0]  data_in, ps_mask, ps_flags, vec_data;
    logic [1:0]  sp_op, pc_op, pc_inc;
    logic [15:0] pc_in;

    logic        vec_req_v, ready_v, vec_req_d, ready_d;
    logic [15:0] vec_addr_v, PC_v, vec_addr_d, PC_d;
    logic [7:0]  A_v, X_v, Y_v, SP_v, PS_v, A_d, X_d, Y_d, SP_d, PS_d;

    int n_checks = 0;
    int n_fail   = 0;
    logic saw_req_d;

    always #5 clk = ~clk;

    cpu_regfile_param u_vec (
        .clk(clk), .reset(reset), .we_a(we_a), .we_x(we_x), .we_y(we_y), .we_sp(we_sp),
        .data_in(data_in), .sp_op(sp_op), .pc_op(pc_op), .pc_inc(pc_inc), .pc_in(pc_in),
        .ps_we(ps_we), .ps_mask(ps_mask), .ps_flags(ps_flags), .vec_data(vec_data),
        .vec_ack(vec_ack), .vec_req(vec_req_v), .vec_addr(vec_addr_v), .ready(ready_v),
        .A(A_v), .X(X_v), .Y(Y_v), .SP(SP_v), .PC(PC_v), .PS(PS_v)
    );

    cpu_regfile_param #(.USE_VECTOR(1'b0)) u_dir (
        .clk(clk), .reset(reset), .we_a(we_a), .we_x(we_x), .we_y(we_y), .we_sp(we_sp),
        .data_in(data_in), .sp_op(sp_op), .pc_op(pc_op), .pc_inc(pc_inc), .pc_in(pc_in),
        .ps_we(ps_we), .ps_mask(ps_mask), .ps_flags(ps_flags), .vec_data(vec_data),
        .vec_ack(vec_ack), .vec_req(vec_req_d), .vec_addr(vec_addr_d), .ready(ready_d),
        .A(A_d), .X(X_d), .Y(Y_d), .SP(SP_d), .PC(PC_d), .PS(PS_d)
    );

    always @(posedge clk or negedge clk)
        if (vec_req_d === 1'b1) saw_req_d = 1'b1;

    task automatic idle_inputs();
        we_a = 0; we_x = 0; we_y = 0; we_sp = 0; ps_we = 0; vec_ack = 0;
        data_in = 8'h00; ps_mask = 8'h00; ps_flags = 8'h00; vec_data = 8'h00;
        sp_op = 2'b00; pc_op = 2'b00; pc_inc = 2'b00; pc_in = 16'h0000;
    endtask

    task automatic step();
        @(negedge clk);
    endtask

    task automatic test_reset();
        reset = 1'b1;
        idle_inputs();
        step();
        n_checks++; if (A_v !== 8'h00) begin n_fail++; $display("FAIL reset_A got %h exp 00", A_v); end
        n_checks++; if (SP_v !== 8'hFD) begin n_fail++; $display("FAIL reset_SP got %h exp FD", SP_v); end
        n_checks++; if (PS_v !== 8'h34) begin n_fail++; $display("FAIL reset_PS got %h exp 34", PS_v); end
        n_checks++; if (PC_v !== 16'h1000) begin n_fail++; $display("FAIL reset_PC got %h exp 1000", PC_v); end
        n_checks++; if ({ready_v, vec_req_v} !== 2'b00) begin n_fail++; $display("FAIL reset_ctl got %b exp 00", {ready_v, vec_req_v}); end
        n_checks++; if (vec_addr_v !== 16'h0000) begin n_fail++; $display("FAIL reset_vaddr got %h exp 0000", vec_addr_v); end
    endtask

    task automatic test_direct();
        saw_req_d = 1'b0;
        reset = 1'b0;
        #1;
        n_checks++; if (ready_d !== 1'b0) begin n_fail++; $display("FAIL direct_boot_ready got %b exp 0", ready_d); end
        step();
        n_checks++; if (ready_d !== 1'b1) begin n_fail++; $display("FAIL direct_ready got %b exp 1", ready_d); end
        n_checks++; if (PC_d !== 16'h1000) begin n_fail++; $display("FAIL direct_PC got %h exp 1000", PC_d); end
        step();
        n_checks++; if (saw_req_d !== 1'b0) begin n_fail++; $display("FAIL direct_vec_req got %b exp 0", saw_req_d); end
        reset = 1'b1;
        step();
    endtask

    task automatic test_vector_fetch();
        reset = 1'b0;
        we_a = 1'b1; data_in = 8'hAA;
        step();
        n_checks++; if ({vec_req_v, vec_addr_v} !== {1'b1, 16'hFFFC}) begin n_fail++; $display("FAIL fetch_lo_req got %b/%h exp 1/FFFC", vec_req_v, vec_addr_v); end
        step();
        step();
        vec_ack = 1'b1; vec_data = 8'h34;
        step();
        vec_ack = 1'b0; vec_data = 8'h00;
        n_checks++; if ({vec_req_v, vec_addr_v} !== {1'b1, 16'hFFFD}) begin n_fail++; $display("FAIL fetch_hi_req got %b/%h exp 1/FFFD", vec_req_v, vec_addr_v); end
        n_checks++; if (PC_v !== 16'h1034) begin n_fail++; $display("FAIL fetch_pc_lo got %h exp 1034", PC_v); end
        step();
        step();
        vec_ack = 1'b1; vec_data = 8'h12;
        #1;
        n_checks++; if (ready_v !== 1'b0) begin n_fail++; $display("FAIL fetch_ready_early got %b exp 0", ready_v); end
        step();
        vec_ack = 1'b0; vec_data = 8'h00;
        n_checks++; if (ready_v !== 1'b1) begin n_fail++; $display("FAIL fetch_ready got %b exp 1", ready_v); end
        n_checks++; if (PC_v !== 16'h1234) begin n_fail++; $display("FAIL fetch_pc got %h exp 1234", PC_v); end
        n_checks++; if ({vec_req_v, vec_addr_v} !== {1'b0, 16'h0000}) begin n_fail++; $display("FAIL run_vec_out got %b/%h exp 0/0000", vec_req_v, vec_addr_v); end
        n_checks++; if (A_v !== 8'h00) begin n_fail++; $display("FAIL fetch_we_ignored got %h exp 00", A_v); end
        we_a = 1'b0;
    endtask

    task automatic test_abx();
        we_a = 1'b1; data_in = 8'h5A;
        step();
        we_a = 1'b0; we_x = 1'b1; we_y = 1'b1; data_in = 8'hC3;
        step();
        idle_inputs();
        n_checks++; if ({A_v, X_v, Y_v} !== 24'h5AC3C3) begin n_fail++; $display("FAIL axy got %h exp 5AC3C3", {A_v, X_v, Y_v}); end
    endtask

    task automatic test_sp();
        we_sp = 1'b1; data_in = 8'h00;
        step();
        we_sp = 1'b0; sp_op = 2'b10;
        step();
        n_checks++; if (SP_v !== 8'hFF) begin n_fail++; $display("FAIL sp_dec_wrap got %h exp FF", SP_v); end
        sp_op = 2'b01;
        step();
        n_checks++; if (SP_v !== 8'h00) begin n_fail++; $display("FAIL sp_inc_wrap got %h exp 00", SP_v); end
        sp_op = 2'b11;
        step();
        n_checks++; if (SP_v !== 8'h00) begin n_fail++; $display("FAIL sp_hold got %h exp 00", SP_v); end
        we_sp = 1'b1; sp_op = 2'b01; data_in = 8'h80;
        step();
        idle_inputs();
        n_checks++; if (SP_v !== 8'h80) begin n_fail++; $display("FAIL sp_we_priority got %h exp 80", SP_v); end
    endtask

    task automatic test_pc();
        pc_op = 2'b10; pc_in = 16'hFFFE;
        step();
        pc_op = 2'b01; pc_inc = 2'd0;
        step();
        n_checks++; if (PC_v !== 16'hFFFE) begin n_fail++; $display("FAIL pc_inc0 got %h exp FFFE", PC_v); end
        pc_inc = 2'd3;
        step();
        n_checks++; if (PC_v !== 16'h0001) begin n_fail++; $display("FAIL pc_inc_wrap got %h exp 0001", PC_v); end
        pc_op = 2'b10; pc_in = 16'hC000;
        step();
        idle_inputs();
        n_checks++; if (PC_v !== 16'hC000) begin n_fail++; $display("FAIL pc_load got %h exp C000", PC_v); end
    endtask

    task automatic test_ps();
        ps_we = 1'b1; data_in = 8'h34;
        step();
        ps_we = 1'b0; ps_mask = 8'hC3; ps_flags = 8'h81;
        step();
        n_checks++; if (PS_v !== 8'hB5) begin n_fail++; $display("FAIL ps_masked got %h exp B5", PS_v); end
        ps_we = 1'b1; data_in = 8'h00;
        step();
        idle_inputs();
        n_checks++; if (PS_v !== 8'h20) begin n_fail++; $display("FAIL ps_load_one got %h exp 20", PS_v); end
    endtask

    task automatic test_abort_refetch();
        reset = 1'b1;
        step();
        reset = 1'b0;
        step();
        vec_ack = 1'b1; vec_data = 8'h34;
        step();
        reset = 1'b1;
        vec_data = 8'h99;
        #1;
        n_checks++; if (PC_v !== 16'h1000) begin n_fail++; $display("FAIL abort_pc got %h exp 1000", PC_v); end
        n_checks++; if ({ready_v, vec_req_v} !== 2'b00) begin n_fail++; $display("FAIL abort_ctl got %b exp 00", {ready_v, vec_req_v}); end
        reset = 1'b0;
        step();
        n_checks++; if ({vec_addr_v, PC_v} !== {16'hFFFC, 16'h1000}) begin n_fail++; $display("FAIL refetch_lo got %h/%h exp FFFC/1000", vec_addr_v, PC_v); end
        vec_data = 8'h78;
        step();
        n_checks++; if ({vec_addr_v, PC_v} !== {16'hFFFD, 16'h1078}) begin n_fail++; $display("FAIL refetch_hi got %h/%h exp FFFD/1078", vec_addr_v, PC_v); end
        vec_data = 8'h56;
        step();
        n_checks++; if ({ready_v, PC_v} !== {1'b1, 16'h5678}) begin n_fail++; $display("FAIL refetch_done got %b/%h exp 1/5678", ready_v, PC_v); end
        vec_data = 8'hEE;
        step();
        idle_inputs();
        n_checks++; if (PC_v !== 16'h5678) begin n_fail++; $display("FAIL run_ack_ignored got %h exp 5678", PC_v); end
    endtask

    initial begin
        test_reset();
        test_direct();
        test_vector_fetch();
        test_abx();
        test_sp();
        test_pc();
        test_ps();
        test_abort_refetch();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
